// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, source ids and the write-back request type
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LD, SRC_FP} src_t;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_hold_slot.sv
// wb_hold_slot: one-entry valid/ready holding register for a write-back source
//   clk, rst (sync, active-low)
//   in_valid, in_req : offered result; accepted when in_valid && ready
//   grant            : arbiter is draining this slot this cycle
//   ready            : slot empty, or being drained this cycle
//   full, req        : held result
module wb_hold_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    ready,
  output logic    full,
  output wb_req_t req
);
  assign ready = !full || grant;
  always_ff @(posedge clk)
    if (!rst) begin
      full <= 1'b0;
      req  <= '0;
    end else if (in_valid && ready) begin
      full <= 1'b1;
      req  <= in_req;
    end else if (grant) begin
      full <= 1'b0;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU, load and FPU results onto the register-file write port
//   clk, rst (sync, active-low)
//   alu_valid/alu_rd/alu_data : single-cycle ALU result, no back-pressure
//   ld_*/fp_*                 : valid/ready load and FPU results, one holding slot each
//   issue_valid/issue_rd      : long-latency op issued; marks its destination busy
//   write_flag/write_reg/write_data : registered register-file write
//   busy_mask                 : pending load/FPU write per register
//   wb_stall                  : ALU must stay idle so a starved slot can drain
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              fp_valid,
  output logic              fp_ready,
  input  logic [REG_AW-1:0] fp_rd,
  input  logic [XLEN-1:0]   fp_data,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              write_flag,
  output logic [REG_AW-1:0] write_reg,
  output logic [XLEN-1:0]   write_data,
  output logic [NREG-1:0]   busy_mask,
  output logic              wb_stall
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  src_t          grant, slot_pick, last_grant;
  logic          ld_full, fp_full, any_full, slot_grant;
  wb_req_t       ld_req, fp_req, alu_req, win;
  logic [CW-1:0] cnt, cnt_n;
  logic [NREG-1:0] set_m, clr_m;
  wb_hold_slot u_ld (
    .clk(clk), .rst(rst), .in_valid(ld_valid), .in_req({ld_rd, ld_data}),
    .grant(grant == SRC_LD), .ready(ld_ready), .full(ld_full), .req(ld_req)
  );
  wb_hold_slot u_fp (
    .clk(clk), .rst(rst), .in_valid(fp_valid), .in_req({fp_rd, fp_data}),
    .grant(grant == SRC_FP), .ready(fp_ready), .full(fp_full), .req(fp_req)
  );
  // A stalled ALU is simply not eligible, so a stall always hands the port to a slot
  // and an illegal alu_valid during a stall is dropped.
  always_comb begin
    alu_req    = '{rd: alu_rd, data: alu_data};
    any_full   = ld_full || fp_full;
    slot_pick  = (ld_full && fp_full) ? ((last_grant == SRC_FP) ? SRC_LD : SRC_FP)
               : (ld_full ? SRC_LD : SRC_FP);
    grant      = (alu_valid && !wb_stall) ? SRC_ALU : (any_full ? slot_pick : SRC_NONE);
    slot_grant = (grant == SRC_LD) || (grant == SRC_FP);
    win        = (grant == SRC_LD) ? ld_req : ((grant == SRC_FP) ? fp_req : alu_req);
    cnt_n      = slot_grant ? '0
               : ((any_full && cnt != CW'(STARVE_LIMIT)) ? cnt + CW'(1) : cnt);
    set_m      = issue_valid ? (NREG'(1) << issue_rd) : '0;
    clr_m      = slot_grant ? (NREG'(1) << win.rd) : '0;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      write_flag <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      busy_mask  <= '0;
      wb_stall   <= 1'b0;
      cnt        <= '0;
      last_grant <= SRC_FP;
    end else begin
      write_flag <= (grant != SRC_NONE) && (win.rd != '0);
      if (grant != SRC_NONE) begin
        write_reg  <= win.rd;
        write_data <= win.data;
      end
      if (slot_grant) last_grant <= grant;
      cnt       <= cnt_n;
      wb_stall  <= cnt_n == CW'(STARVE_LIMIT);
      // set after clear so a re-issue to the register being written stays pending
      busy_mask <= ((busy_mask & ~clr_m) | set_m) & ~NREG'(1);
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus, behavioural model compared every cycle
module tb_regfile_wb_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic alu_valid = 1'b0, ld_valid = 1'b0, fp_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0] alu_rd = '0, ld_rd = '0, fp_rd = '0, issue_rd = '0;
  logic [31:0] alu_data = '0, ld_data = '0, fp_data = '0;
  logic ld_ready, fp_ready, write_flag, wb_stall;
  logic [4:0] write_reg;
  logic [31:0] write_data, busy_mask;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .fp_valid(fp_valid), .fp_ready(fp_ready), .fp_rd(fp_rd), .fp_data(fp_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .write_flag(write_flag), .write_reg(write_reg), .write_data(write_data),
    .busy_mask(busy_mask), .wb_stall(wb_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: what each slot holds, who won last, how long a result has waited.
  bit m_on = 0, ld_f = 0, fp_f = 0, last_fp = 1, m_stall = 0, m_flag = 0;
  logic [4:0] ld_r = '0, fp_r = '0, m_reg = '0;
  logic [31:0] ld_d = '0, fp_d = '0, m_data = '0;
  bit [31:0] m_busy = '0;
  int wait_n = 0;

  // 0 none, 1 ALU, 2 load, 3 FPU
  function automatic int pick();
    if (alu_valid && !m_stall) return 1;
    if (ld_f && fp_f) return last_fp ? 2 : 3;
    if (ld_f) return 2;
    if (fp_f) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin
    int g;
    bit lr, fr;
    logic [4:0] r;
    logic [31:0] d;
    g  = pick();
    lr = !ld_f || g == 2;
    fr = !fp_f || g == 3;
    if (!rst) begin
      m_on = 1; ld_f = 0; fp_f = 0; last_fp = 1; wait_n = 0; m_stall = 0;
      m_busy = '0; m_flag = 0; m_reg = '0; m_data = '0;
    end else if (m_on) begin
      r = (g == 1) ? alu_rd : ((g == 2) ? ld_r : fp_r);
      d = (g == 1) ? alu_data : ((g == 2) ? ld_d : fp_d);
      m_flag = g != 0 && r != 0;
      if (g != 0) begin m_reg = r; m_data = d; end
      if (g >= 2) begin
        wait_n = 0;
        m_busy[r] = 1'b0;
        last_fp = g == 3;
      end else if (ld_f || fp_f) wait_n = (wait_n < LIM) ? wait_n + 1 : LIM;
      m_stall = wait_n == LIM;
      if (issue_valid) m_busy[issue_rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (g == 2) ld_f = 0;
      if (g == 3) fp_f = 0;
      if (ld_valid && lr) begin ld_f = 1; ld_r = ld_rd; ld_d = ld_data; end
      if (fp_valid && fr) begin fp_f = 1; fp_r = fp_rd; fp_d = fp_data; end
    end
  end

  always @(negedge clk) if (m_on) begin
    int g;
    g = pick();
    chk("m_ld_ready", 32'(ld_ready), 32'(!ld_f || g == 2));
    chk("m_fp_ready", 32'(fp_ready), 32'(!fp_f || g == 3));
    chk("m_write_flag", 32'(write_flag), 32'(m_flag));
    chk("m_write_reg", 32'(write_reg), 32'(m_reg));
    chk("m_write_data", write_data, m_data);
    chk("m_busy_mask", busy_mask, m_busy);
    chk("m_wb_stall", 32'(wb_stall), 32'(m_stall));
  end

  always @(posedge clk)
    if (rst) assert (!(wb_stall && alu_valid)) else $error("FAIL protocol: alu_valid while wb_stall");

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    cyc(); cyc();
    rst = 1'b1;
    chk("rst_flag", 32'(write_flag), 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stall", 32'(wb_stall), 0);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    // ALU stream 5/6/7
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(5 + i); alu_data = 32'(17 * (i + 1));
      cyc();
      chk("alu_flag", 32'(write_flag), 1);
      chk("alu_reg", 32'(write_reg), 32'(5 + i));
      chk("alu_data", write_data, 32'(17 * (i + 1)));
    end
    alu_valid = 1'b0;
    cyc();
    chk("alu_idle_flag", 32'(write_flag), 0);
    chk("alu_hold_reg", 32'(write_reg), 7);
    // load + FPU accepted together
    issue_valid = 1'b1; issue_rd = 5'd9; cyc();
    issue_rd = 5'd10; cyc();
    issue_valid = 1'b0;
    chk("busy_9_10", busy_mask, 32'h600);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'hDEADBEEF;
    fp_valid = 1'b1; fp_rd = 5'd10; fp_data = 32'h3F800000;
    cyc();
    ld_valid = 1'b0; fp_valid = 1'b0;
    chk("accept_no_write", 32'(write_flag), 0);
    cyc();
    chk("ld_first_reg", 32'(write_reg), 9);
    chk("ld_first_data", write_data, 32'hDEADBEEF);
    chk("ld_busy_clear", busy_mask, 32'h400);
    cyc();
    chk("fp_second_reg", 32'(write_reg), 10);
    chk("fp_second_data", write_data, 32'h3F800000);
    chk("fp_busy_clear", busy_mask, 0);
    // FPU starved by ALU traffic
    issue_valid = 1'b1; issue_rd = 5'd12; cyc();
    issue_valid = 1'b0;
    fp_valid = 1'b1; fp_rd = 5'd12; fp_data = 32'hCAFEF00D;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd1;
    cyc();
    fp_valid = 1'b0;
    k = 0;
    while (!wb_stall && k < 20) begin
      alu_data = alu_data + 32'd1;
      cyc();
      k++;
    end
    alu_valid = 1'b0;
    chk("starve_cycles", 32'(k), 4);
    cyc();
    chk("starve_reg", 32'(write_reg), 12);
    chk("starve_flag", 32'(write_flag), 1);
    chk("starve_data", write_data, 32'hCAFEF00D);
    chk("starve_stall_clear", 32'(wb_stall), 0);
    chk("starve_busy", busy_mask, 0);
    // load to x0
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFFFFFF;
    chk("rd0_ready", 32'(ld_ready), 1);
    cyc();
    ld_valid = 1'b0;
    cyc();
    chk("rd0_no_write", 32'(write_flag), 0);
    chk("rd0_busy", busy_mask, 0);
    chk("rd0_slot_free", 32'(ld_ready), 1);
    // reset while both slots are full
    issue_valid = 1'b1; issue_rd = 5'd9; cyc();
    issue_rd = 5'd10; cyc();
    issue_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'd1;
    fp_valid = 1'b1; fp_rd = 5'd10; fp_data = 32'd2;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    cyc();
    chk("mid_busy", busy_mask, 32'h600);
    chk("mid_ld_ready", 32'(ld_ready), 0);
    chk("mid_fp_ready", 32'(fp_ready), 0);
    ld_valid = 1'b0; fp_valid = 1'b0; alu_valid = 1'b0; rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("mid_rst_ld_ready", 32'(ld_ready), 1);
    chk("mid_rst_fp_ready", 32'(fp_ready), 1);
    chk("mid_rst_busy", busy_mask, 0);
    chk("mid_rst_flag", 32'(write_flag), 0);
    chk("mid_rst_stall", 32'(wb_stall), 0);
    // re-issue to the register the FPU is writing
    issue_valid = 1'b1; issue_rd = 5'd3; cyc();
    issue_valid = 1'b0;
    fp_valid = 1'b1; fp_rd = 5'd3; fp_data = 32'h33333333;
    cyc();
    fp_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3;
    cyc();
    issue_valid = 1'b0;
    chk("reissue_flag", 32'(write_flag), 1);
    chk("reissue_reg", 32'(write_reg), 3);
    chk("reissue_busy", busy_mask, 32'h8);
    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
